keypad_debounce: RTL

KEYPAD_DEBOUNCE -- requirements
Module: keypad_debounce

---
 rtl/doorlock_pkg.sv | 23 ++
 rtl/debounce_bit.sv | 51 +++++
 rtl/keypad_debounce.sv | 76 +++++++
 3 files changed

// File: rtl/doorlock_pkg.sv
// Shared constants and helpers for the door-lock keypad front end.
package doorlock_pkg;

  localparam int unsigned NUM_KEYS          = 10;
  localparam int unsigned CODE_W            = 4;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned STABLE_CYCLES_DEF = 3;

  function automatic logic [CODE_W-1:0] onehot_to_code(input logic [NUM_KEYS-1:0] v);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic is_multi_hot(input logic [NUM_KEYS-1:0] v);
    return (v & (v - NUM_KEYS'(1))) != '0;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchronizer followed by a stability counter for one bouncy input.
module debounce_bit
  import doorlock_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic state
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_CYCLES);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Any sample matching the accepted level restarts the count, so bounces never accumulate.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_inc == LIMIT) begin
      state_d = ~state_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/keypad_debounce.sv
// Debounces ten digit keys and an enter key, producing levels and single press pulses.
module keypad_debounce
  import doorlock_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                x_raw,
  output logic [NUM_KEYS-1:0] num,
  output logic                x,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code,
  output logic                x_pulse,
  output logic                multi_key
);

  logic [NUM_KEYS-1:0] digit_state;
  logic                x_state;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_digit
    debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (key_raw[i]),
      .state (digit_state[i])
    );
  end

  debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_db_x (
    .clock (clock),
    .reset (reset),
    .raw   (x_raw),
    .state (x_state)
  );

  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              x_pulse_q, x_pulse_d;
  logic              x_prev_q, x_prev_d;
  logic              rearm_q, rearm_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      x_pulse_q   <= 1'b0;
      x_prev_q    <= 1'b0;
      rearm_q     <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      x_pulse_q   <= x_pulse_d;
      x_prev_q    <= x_prev_d;
      rearm_q     <= rearm_d;
    end
  end

  // rearm_q means "all digits were released last cycle", so only a 0 -> one-hot step fires.
  always_comb begin
    multi_key   = is_multi_hot(digit_state);
    num         = multi_key ? '0 : digit_state;
    x           = x_state;
    rearm_d     = (digit_state == '0);
    key_valid_d = rearm_q && (num != '0);
    key_code_d  = key_valid_d ? onehot_to_code(num) : key_code_q;
    x_prev_d    = x_state;
    x_pulse_d   = x_state && !x_prev_q;
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign x_pulse   = x_pulse_q;

endmodule
